// File: rtl/lsb_serializer.sv
// lsb_serializer
//   Parallel-to-serial front end for the serial two's-complement converter.
//   Takes WIDTH-bit words over a valid/ready handshake and shifts them out
//   LSB first, one bit per t_clk cycle. ser_start marks each word's LSB
//   cycle and drives the converter's reset/start input. ser_last marks the
//   MSB cycle. A new word can be accepted on the MSB cycle of the current
//   word, so words can stream back-to-back with no gap.
//
// Ports
//   t_clk       rising-edge clock
//   r           synchronous active-high reset
//   load_valid  load_data holds a word to serialize
//   load_data   parallel word, bit 0 is sent first
//   load_ready  word can be accepted this cycle (combinational)
//   ser_bit     current serial bit (registered)
//   ser_start   high on the LSB cycle of each word (registered)
//   ser_last    high on the MSB cycle of each word (registered)
//   ser_valid   ser_bit carries word data (registered)

module lsb_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_bit,
    output logic             ser_start,
    output logic             ser_last,
    output logic             ser_valid
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("lsb_serializer: WIDTH must be in 2..32");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [WIDTH-1:0] w_shifted;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CW-1:0]    w_cnt_inc;

    logic r_ser_bit,   w_bit_nxt;
    logic r_ser_start, w_start_nxt;
    logic r_ser_last,  w_last_nxt;
    logic r_ser_valid, w_valid_nxt;

    logic w_at_msb;
    logic w_accept;

    // The MSB cycle is the only SHIFT cycle in which a reload is allowed;
    // that is what makes gapless streaming possible.
    assign w_at_msb   = (r_state == SHIFT) && (r_cnt == LAST_CNT);
    assign load_ready = !r && ((r_state == IDLE) || w_at_msb);
    assign w_accept   = load_valid && load_ready;

    assign w_shifted = r_shreg >> 1;
    assign w_cnt_inc = r_cnt + CW'(1);

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = 1'b0;
        w_start_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_valid_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SHIFT;
                    w_shreg_nxt = load_data;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = load_data[0];
                    w_start_nxt = 1'b1;
                    w_valid_nxt = 1'b1;
                end
            end

            SHIFT: begin
                if (!w_at_msb) begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_shreg_nxt = w_shifted;
                    w_bit_nxt   = w_shifted[0];
                    w_valid_nxt = 1'b1;
                    // Flag the MSB one cycle ahead so it lands registered.
                    w_last_nxt  = (w_cnt_inc == LAST_CNT);
                end else if (w_accept) begin
                    // Reload on the MSB cycle exactly as from IDLE.
                    w_state_nxt = SHIFT;
                    w_shreg_nxt = load_data;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = load_data[0];
                    w_start_nxt = 1'b1;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                    w_shreg_nxt = '0;
                    w_cnt_nxt   = '0;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_shreg_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge t_clk) begin
        if (r) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_ser_bit   <= 1'b0;
            r_ser_start <= 1'b0;
            r_ser_last  <= 1'b0;
            r_ser_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ser_bit   <= w_bit_nxt;
            r_ser_start <= w_start_nxt;
            r_ser_last  <= w_last_nxt;
            r_ser_valid <= w_valid_nxt;
        end
    end

    assign ser_bit   = r_ser_bit;
    assign ser_start = r_ser_start;
    assign ser_last  = r_ser_last;
    assign ser_valid = r_ser_valid;

endmodule
